// File: rtl/br_write_arbiter_pkg.sv
// br_pkg: shared types and constants for the register-bank write arbiter.
//   state_t   : arbiter phase (INIT = zero-clear sequence, RUN = arbitration)
//   NUM_REGS  : number of registers in the bank
//   DIR_W     : register address width
//   DATA_W    : register data width
//   REQ_A/B   : grant / valid vector bit positions for ALU (A) and load (B)
package br_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DIR_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REQ_A    = 0;
    localparam int unsigned REQ_B    = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/br_write_arbiter_if.sv
// br_write_arbiter_if: writeback requesters A/B plus the register-bank
// write port.
//   a_/b_valid, a_/b_dir, a_/b_dato : requester write request
//   a_/b_ready                      : requester accepted this cycle
//   br_we, br_dir, br_dato          : register bank write port
// Modports:
//   slave  : the arbiter (consumes requests, drives readies and bank port)
//   master : the requester / bank side
interface br_write_arbiter_if;
    import br_pkg::*;

    logic              a_valid;
    logic              a_ready;
    logic [DIR_W-1:0]  a_dir;
    logic [DATA_W-1:0] a_dato;

    logic              b_valid;
    logic              b_ready;
    logic [DIR_W-1:0]  b_dir;
    logic [DATA_W-1:0] b_dato;

    logic              br_we;
    logic [DIR_W-1:0]  br_dir;
    logic [DATA_W-1:0] br_dato;

    modport slave (
        input  a_valid, a_dir, a_dato,
        input  b_valid, b_dir, b_dato,
        output a_ready, b_ready,
        output br_we, br_dir, br_dato
    );

    modport master (
        output a_valid, a_dir, a_dato,
        output b_valid, b_dir, b_dato,
        input  a_ready, b_ready,
        input  br_we, br_dir, br_dato
    );

endinterface

// File: rtl/br_rr_arb2.sv
// br_rr_arb2: stateless 2-way round-robin grant.
//   valid  : request vector, bit REQ_A = A, bit REQ_B = B
//   rr_ptr : requester favoured on contention (0 = A, 1 = B)
//   hold   : suppresses every grant
//   grant  : one-hot grant (all zero when nothing is granted)
module br_rr_arb2
    import br_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    input  logic       hold,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (!hold) begin
            unique case (valid)
                2'b01:   grant[REQ_A] = 1'b1;
                2'b10:   grant[REQ_B] = 1'b1;
                2'b11:   grant[rr_ptr] = 1'b1;
                default: grant = '0;
            endcase
        end
    end

endmodule

// File: rtl/br_write_arbiter.sv
// br_write_arbiter: owns the register bank write port. After reset it
// optionally zero-clears all registers, then shares the port between the
// ALU (A) and load (B) writeback requesters round-robin.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   hold       : freezes the write port (no accepts, no clear progress)
//   bus        : requester handshakes and registered bank write port
//   init_done  : high once arbitration is running
//   wr_count   : committed (bank-visible) writes since the clear finished
module br_write_arbiter
    import br_pkg::*;
#(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter bit          R0_PROTECT     = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    br_write_arbiter_if.slave    bus,
    output logic                 init_done,
    output logic [CNT_W-1:0]     wr_count
);

    state_t            state, state_nxt;
    logic [DIR_W-1:0]  clr_idx, clr_idx_nxt;
    logic              rr_ptr, rr_ptr_nxt;
    logic              we_nxt;
    logic [DIR_W-1:0]  dir_nxt;
    logic [DATA_W-1:0] dato_nxt;
    logic              done_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic [1:0]        valid;
    logic [1:0]        grant;
    logic              arb_hold;
    logic [DIR_W-1:0]  sel_dir;
    logic [DATA_W-1:0] sel_dato;

    assign valid = {bus.b_valid, bus.a_valid};

    // No grants until init_done is registered; this also gives the
    // no-clear configuration its single idle edge before arbitration.
    assign arb_hold = hold | ~init_done | (state != RUN);

    br_rr_arb2 u_arb (
        .valid  (valid),
        .rr_ptr (rr_ptr),
        .hold   (arb_hold),
        .grant  (grant)
    );

    assign bus.a_ready = grant[REQ_A];
    assign bus.b_ready = grant[REQ_B];

    assign sel_dir  = grant[REQ_B] ? bus.b_dir  : bus.a_dir;
    assign sel_dato = grant[REQ_B] ? bus.b_dato : bus.a_dato;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR_ON_RESET ? INIT : RUN;
            clr_idx     <= '0;
            rr_ptr      <= 1'b0;
            bus.br_we   <= 1'b0;
            bus.br_dir  <= '0;
            bus.br_dato <= '0;
            init_done   <= 1'b0;
            wr_count    <= '0;
        end else begin
            state       <= state_nxt;
            clr_idx     <= clr_idx_nxt;
            rr_ptr      <= rr_ptr_nxt;
            bus.br_we   <= we_nxt;
            bus.br_dir  <= dir_nxt;
            bus.br_dato <= dato_nxt;
            init_done   <= done_nxt;
            wr_count    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        rr_ptr_nxt  = rr_ptr;
        we_nxt      = 1'b0;
        dir_nxt     = bus.br_dir;
        dato_nxt    = bus.br_dato;
        done_nxt    = init_done;
        cnt_nxt     = wr_count;

        unique case (state)
            INIT: begin
                if (!hold) begin
                    we_nxt      = 1'b1;
                    dir_nxt     = clr_idx;
                    dato_nxt    = '0;
                    clr_idx_nxt = clr_idx + DIR_W'(1);
                    if (clr_idx == DIR_W'(NUM_REGS - 1)) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                    end
                end
            end
            RUN: begin
                done_nxt = 1'b1;
                if (|grant) begin
                    // Favour whichever requester was not just served.
                    rr_ptr_nxt = grant[REQ_A];
                    // Writes to r0 finish the handshake but never reach the bank.
                    if (!(R0_PROTECT && sel_dir == '0)) begin
                        we_nxt   = 1'b1;
                        dir_nxt  = sel_dir;
                        dato_nxt = sel_dato;
                        cnt_nxt  = wr_count + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
    end

endmodule

// File: tb/tb_br_write_arbiter.sv
module tb_br_write_arbiter;

    typedef struct {
        logic [4:0]  dir;
        logic [31:0] dato;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        init_done;
    logic [15:0] wr_count;

    br_write_arbiter_if bus();

    br_write_arbiter #(
        .CLEAR_ON_RESET (1'b1),
        .R0_PROTECT     (1'b1),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .bus       (bus),
        .init_done (init_done),
        .wr_count  (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // Reference model: expected bank writes in order, plus the visible
    // (pre-edge) values of init_done and the readies for this cycle.
    exp_t        q[$];
    logic        chk_en       = 1'b0;
    logic        exp_done_vis = 1'b0;
    logic        exp_ar       = 1'b0;
    logic        exp_br       = 1'b0;
    int unsigned m_idx        = 0;
    logic        m_done       = 1'b0;
    logic        m_fav        = 1'b0;   // 0: A wins a tie, 1: B wins
    logic [15:0] m_cnt        = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_idx  = 0;
        m_done = 1'b0;
        m_fav  = 1'b0;
        m_cnt  = '0;
        exp_done_vis = 1'b0;
        exp_ar = 1'b0;
        exp_br = 1'b0;
    endtask

    // Drive one cycle of inputs, predict what the next edge does, wait for it.
    task automatic step(input logic h,
                        input logic av, input logic [4:0] ad, input logic [31:0] adt,
                        input logic bv, input logic [4:0] bd, input logic [31:0] bdt);
        logic        ga, gb;
        logic [4:0]  d;
        logic [31:0] v;
        hold        = h;
        bus.a_valid = av; bus.a_dir = ad; bus.a_dato = adt;
        bus.b_valid = bv; bus.b_dir = bd; bus.b_dato = bdt;
        exp_done_vis = m_done;
        if (!m_done) begin
            exp_ar = 1'b0;
            exp_br = 1'b0;
            if (!h) begin
                q.push_back('{dir: 5'(m_idx), dato: 32'h0, cnt: m_cnt});
                m_idx++;
                if (m_idx == 32) m_done = 1'b1;
            end
        end else begin
            ga = !h && av && (!bv || !m_fav);
            gb = !h && bv && (!av ||  m_fav);
            exp_ar = ga;
            exp_br = gb;
            if (ga || gb) begin
                d = ga ? ad  : bd;
                v = ga ? adt : bdt;
                m_fav = ga;
                if (d != 5'd0) begin
                    m_cnt = m_cnt + 16'd1;
                    q.push_back('{dir: d, dato: v, cnt: m_cnt});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: compares handshake/status every cycle and pops one expected
    // entry whenever the bank port shows a write.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && chk_en) begin
            chk("init_done", 64'(init_done), 64'(exp_done_vis));
            chk("a_ready", 64'(bus.a_ready), 64'(exp_ar));
            chk("b_ready", 64'(bus.b_ready), 64'(exp_br));
            if (bus.br_we) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_write: got dir %0d dato 0x%0h expected none at %0t",
                             bus.br_dir, bus.br_dato, $time);
                end else begin
                    e = q.pop_front();
                    chk("br_dir", 64'(bus.br_dir), 64'(e.dir));
                    chk("br_dato", 64'(bus.br_dato), 64'(e.dato));
                    chk("wr_count", 64'(wr_count), 64'(e.cnt));
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_br_we"},     64'(bus.br_we),   64'd0);
        chk({tag, "_br_dir"},    64'(bus.br_dir),  64'd0);
        chk({tag, "_br_dato"},   64'(bus.br_dato), 64'd0);
        chk({tag, "_init_done"}, 64'(init_done),   64'd0);
        chk({tag, "_wr_count"},  64'(wr_count),    64'd0);
        chk({tag, "_a_ready"},   64'(bus.a_ready), 64'd0);
        chk({tag, "_b_ready"},   64'(bus.b_ready), 64'd0);
    endtask

    initial begin
        logic        apend, bpend;
        logic [4:0]  ad, bd;
        logic [31:0] adt, bdt;

        rst_n = 1'b0;
        hold  = 1'b0;
        bus.a_valid = 1'b0; bus.a_dir = '0; bus.a_dato = '0;
        bus.b_valid = 1'b0; bus.b_dir = '0; bus.b_dato = '0;
        model_reset();

        #12;
        chk_reset_outputs("reset");

        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Clear with a 5-cycle hold at clr_idx = 10.
        idle(10);
        for (int unsigned i = 0; i < 5; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(22);
        chk("init_mid_clear", 64'(init_done), 64'd1);

        // A only.
        step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(1);
        // B only, then contention A dir1 / B dir2 for 4 cycles.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0099);
        for (int unsigned i = 0; i < 4; i++)
            step(1'b0, 1'b1, 5'd1, 32'h1111_0000 + i, 1'b1, 5'd2, 32'h2222_0000 + i);
        idle(1);
        // B writes r0: handshake completes, no bank write, favour moves to A.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5);
        step(1'b0, 1'b1, 5'd4, 32'hA4, 1'b1, 5'd5, 32'hB5);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hB5);
        idle(2);

        // Randomized traffic obeying the requester stability rules.
        apend = 1'b0; bpend = 1'b0;
        ad = '0; bd = '0; adt = '0; bdt = '0;
        for (int unsigned i = 0; i < 400; i++) begin
            if (!apend) begin
                apend = ($urandom_range(0, 2) != 0);
                ad    = 5'($urandom_range(0, 31));
                adt   = $urandom;
            end
            if (!bpend) begin
                bpend = ($urandom_range(0, 2) != 0);
                bd    = 5'($urandom_range(0, 31));
                bdt   = $urandom;
            end
            step(($urandom_range(0, 4) == 0), apend, ad, adt, bpend, bd, bdt);
            if (exp_ar) apend = 1'b0;
            if (exp_br) bpend = 1'b0;
        end
        idle(2);
        chk("queue_drained_run", 64'(q.size()), 64'd0);
        chk("count_run", 64'(wr_count), 64'(m_cnt));

        // Reset pulse while A is valid and would be granted.
        bus.a_valid = 1'b1; bus.a_dir = 5'd7; bus.a_dato = 32'h7777_7777;
        hold   = 1'b0;
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_held_we", 64'(bus.br_we), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(32);
        step(1'b0, 1'b1, 5'd7, 32'h7777_7777, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b1, 5'd8, 32'h8888_8888, 1'b1, 5'd8, 32'h0808_0808);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0808_0808);
        idle(3);
        chk("queue_drained_end", 64'(q.size()), 64'd0);
        chk("count_end", 64'(wr_count), 64'(m_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/br_write_arbiter.md
Name: br_write_arbiter

Overview:
- Owns the single write port (WE/Dir/Dato) of the 32x32 register bank and shares it between two writeback requesters: A = ALU result, B = memory-load result.
- After reset, sequences a clear of all 32 registers to zero, then arbitrates round-robin with a valid/ready handshake.
- Sits between the writeback stage and the register bank; read ports are untouched.

Parameters:
- CLEAR_ON_RESET, 1, 1 = run the 32-cycle zero-clear sequence after reset; 0 = go straight to RUN.
- R0_PROTECT, 1, 1 = accepted writes to Dir 0 complete the handshake but are dropped (br_we stays 0).
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  freezes the write port; no accepts and no clear progress while high.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A accepted this cycle (combinational).
- a_dir  in  5  A destination register.
- a_dato  in  32  A write data.
- b_valid, b_ready, b_dir, b_dato: same as A, for requester B.
- br_we  out  1  register bank write enable (registered).
- br_dir  out  5  register bank write address (registered).
- br_dato  out  32  register bank write data (registered).
- init_done  out  1  high once in RUN.
- wr_count  out  CNT_W  committed writes in RUN.

Behaviour:
- Reset (async, rst_n=0): state=INIT if CLEAR_ON_RESET=1, else RUN. clr_idx=0, rr_ptr=0 (A favoured), br_we=0, br_dir=0, br_dato=0, init_done=0, wr_count=0. Reset mid-sequence or mid-transfer discards everything; no partial write is issued.
- INIT:
  - a_ready=b_ready=0.
  - Each edge with hold=0 registers br_we=1, br_dir=clr_idx, br_dato=0, then increments clr_idx.
  - With hold=1: br_we=0 and clr_idx holds.
  - The edge that registers clr_idx=31 also sets state=RUN and init_done=1. Unstalled, the clear spans edges 1..32 after reset release.
- CLEAR_ON_RESET=0: the first edge sets state=RUN and init_done=1, with br_we=0.
- RUN grant (combinational):
  - hold=1 gives no grant.
  - Exactly one valid: that requester is granted.
  - Both valid: the requester selected by rr_ptr is granted.
  - x_ready = grant to x. Handshake completes when x_valid and x_ready are both high at the edge.
- rr_ptr update: on every completed handshake, rr_ptr is set to the non-granted requester. Consequence: under continuous contention grants alternate A, B, A, ...
- Commit latency is 1 cycle. On the accept edge, br_we=1 and br_dir/br_dato take the granted dir/dato.
  - Exception: R0_PROTECT=1 and dir=0 gives br_we=0 and no count.
- No accept: br_we=0; br_dir/br_dato hold their last values.
- wr_count increments on each edge that registers br_we=1 in RUN. It wraps from 2^CNT_W-1 to 0. Clear writes are not counted.
- Same dir from A and B in consecutive grants: the later grant wins in the bank. The arbiter does no merging.
- Requester rules: a requester holding valid must keep dir/dato stable until accepted. A loser keeps valid and is granted on the next unheld cycle.
- init_done, once set, stays 1 until reset.

Decomposition:
- Shared package br_pkg: state enum {INIT, RUN}, NUM_REGS=32, DIR_W=5, DATA_W=32, REQ_A=0, REQ_B=1.
- One sub-module: br_rr_arb2, a 2-way round-robin grant. Inputs: valid pair, rr_ptr, hold. Output: one-hot grant. It holds no state; rr_ptr lives in the parent.

Test Plan:
- Reset release, hold=0, CLEAR_ON_RESET=1 -> br_we=1 with br_dir=0..31 and br_dato=0 on edges 1..32; init_done=1 after edge 32; both readies 0 throughout; wr_count=0.
- Clear with hold=1 for 5 cycles at clr_idx=10 -> br_we=0 for those 5 cycles, then resumes at br_dir=10; init_done is delayed by 5 cycles.
- RUN, A only (dir=3, dato=0xDEADBEEF) -> a_ready=1 the same cycle; next edge br_we=1, br_dir=3, br_dato=0xDEADBEEF; wr_count=1.
- RUN, A and B valid continuously for 4 cycles (A dir=1, B dir=2), rr_ptr=0 -> grants A, B, A, B; br_dir sequence 1, 2, 1, 2; wr_count += 4.
- R0_PROTECT=1, B writes dir=0 dato=0x5 -> b_ready=1, handshake completes; br_we stays 0; wr_count unchanged; rr_ptr moves to A.
- rst_n pulsed low while A valid and granted -> outputs zero immediately; no write is committed; the clear sequence restarts from br_dir=0.
